// File: rtl/ro_bus_arbiter_pkg.sv
// Shared types and constants for the read-only bus arbiter.
package ro_bus_arbiter_pkg;

    localparam int ARCH_LEN  = 32;
    localparam int ICLLEN    = 64;
    localparam int RO_MAX_CH = 8;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} ro_arb_state_t;

    // One-hot to index over the widest supported channel vector.
    function automatic logic [2:0] oh2idx(input logic [RO_MAX_CH-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < RO_MAX_CH; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ro_bus_arbiter_if.sv
// ldp/ldr load-handshake bundle; N lanes of address/petition/ready share one data line.
interface ro_bus #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [N-1:0][ADDR_W-1:0] addr;
    logic [N-1:0]             ldp;
    logic [N-1:0]             ldr;
    logic [DATA_W-1:0]        ldData;

    modport master (output addr, output ldp, input ldr, input ldData);
    modport slave  (input addr, input ldp, output ldr, output ldData);
endinterface

// File: rtl/ro_bus_arbiter_rr.sv
// Combinational round-robin pick: first requester after the last winner.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] last_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(last_i) + k) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ro_bus_arbiter.sv
// Shares one memory read port among NUM_CH load channels, one request at a time,
// round-robin; all outputs registered.
module ro_bus_arbiter
    import ro_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = ARCH_LEN,
    parameter int DATA_W = ICLLEN
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    ro_bus.slave              ch_bus,
    ro_bus.master             mem_bus,
    output logic [NUM_CH-1:0] grant_o,
    output logic              busy_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    ro_arb_state_t     state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] ldr_q, ldr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              mem_ldp_q, mem_ldp_d;

    logic [NUM_CH-1:0] rr_gnt;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  own_idx;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .req_i  (ch_bus.ldp),
        .last_i (ptr_q),
        .gnt_o  (rr_gnt)
    );

    assign win_idx = PTR_W'(oh2idx(RO_MAX_CH'(rr_gnt)));
    assign own_idx = PTR_W'(oh2idx(RO_MAX_CH'(grant_q)));

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ldr_q     <= '0;
            ptr_q     <= PTR_W'(NUM_CH - 1);
            addr_q    <= '0;
            data_q    <= '0;
            mem_ldp_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ldr_q     <= ldr_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mem_ldp_q <= mem_ldp_d;
        end
    end

    // Outputs for the following cycle are decided here so every port comes off a flop.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ldr_d     = '0;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        mem_ldp_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|ch_bus.ldp) begin
                    state_d   = MEM_WAIT;
                    grant_d   = rr_gnt;
                    addr_d    = ch_bus.addr[win_idx];
                    mem_ldp_d = 1'b1;
                end
            end
            MEM_WAIT: begin
                mem_ldp_d = 1'b1;
                if (mem_bus.ldr[0]) begin
                    state_d   = RESP;
                    data_d    = mem_bus.ldData;
                    ldr_d     = grant_q;
                    mem_ldp_d = 1'b0;
                end
            end
            RESP: begin
                ptr_d   = own_idx;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_bus.addr[0] = addr_q;
    assign mem_bus.ldp[0]  = mem_ldp_q;
    assign ch_bus.ldr      = ldr_q;
    assign ch_bus.ldData   = data_q;
    assign grant_o         = grant_q;
    assign busy_o          = (state_q != IDLE);

endmodule
